pipe_ctrl: RTL

Pipeline sequencing controller for the five-stage RISC-V core used by the FFT/IFFT firmware. It detects load-use hazards, generates branch/jump flushes, and stalls the front end and ID/EX stage while a multi-cycle EX operation (butterfly multiply) is in flight. It drives the hold/flush/bubble inputs of the IF/ID and ID/EX pipeline registers, and the bubble input of EX/MEM.

---
 rtl/pipe_ctrl_pkg.sv | 17 +
 rtl/pipe_ctrl_hazard_detect.sv | 21 ++
 rtl/pipe_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared state encodings and defaults for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN     = 2'd0,
      ST_MC_WAIT = 2'd1,
      ST_FLUSH   = 2'd2
   } pipe_state_e;

   localparam int MC_TIMEOUT_DEF   = 64;
   localparam int FLUSH_CYCLES_DEF = 1;
   localparam int REG_AW           = 5;

   // x0 is hardwired to zero, so a write to it never produces a value to wait for.
   localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparison: a load in EX whose destination is read by the instruction in ID.
module pipe_ctrl_hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_reg_waddr,
   input  logic              ex_mem_rena,
   output logic              hazard_o
);

   logic rs1_match;
   logic rs2_match;

   assign rs1_match = id_rs1_used && (id_rs1_addr == ex_reg_waddr);
   assign rs2_match = id_rs2_used && (id_rs2_addr == ex_reg_waddr);
   assign hazard_o  = ex_mem_rena && (ex_reg_waddr != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: redirect flush, multi-cycle EX stall, load-use stall.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MC_TIMEOUT   = MC_TIMEOUT_DEF,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs1_addr,
   input  logic [REG_AW-1:0] id_rs2_addr,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] ex_reg_waddr,
   input  logic              ex_mem_rena,
   input  logic              ex_redirect,
   input  logic              ex_mc_start,
   input  logic              mc_done,
   output logic              pc_hold,
   output logic              ifid_hold,
   output logic              ifid_flush,
   output logic              idex_hold,
   output logic              idex_hazarded,
   output logic              pipelineFlush,
   output logic              exmem_bubble,
   output logic              mc_timeout,
   output logic [1:0]        state_o
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [31:0]      stall_cycles,
   output logic [15:0]       flush_count
`endif
);

   localparam int TW = $clog2(MC_TIMEOUT) + 1;
   localparam logic [TW-1:0] TMO_LAST   = TW'(MC_TIMEOUT - 1);
   localparam logic [2:0]    FLUSH_LOAD = 3'(FLUSH_CYCLES);

   pipe_state_e   state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [TW-1:0] tmo_q, tmo_d;

   logic hazard;
   logic pc_hold_c, ifid_hold_c, ifid_flush_c, idex_hold_c;
   logic idex_hazarded_c, pflush_c, exmem_bubble_c, mc_timeout_c;
   logic redirect_acc;

   pipe_ctrl_hazard_detect u_hazard (
      .id_rs1_addr  (id_rs1_addr),
      .id_rs2_addr  (id_rs2_addr),
      .id_rs1_used  (id_rs1_used),
      .id_rs2_used  (id_rs2_used),
      .ex_reg_waddr (ex_reg_waddr),
      .ex_mem_rena  (ex_mem_rena),
      .hazard_o     (hazard)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         cnt_q   <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      tmo_d           = tmo_q;
      pc_hold_c       = 1'b0;
      ifid_hold_c     = 1'b0;
      ifid_flush_c    = 1'b0;
      idex_hold_c     = 1'b0;
      idex_hazarded_c = 1'b0;
      pflush_c        = 1'b0;
      exmem_bubble_c  = 1'b0;
      mc_timeout_c    = 1'b0;
      redirect_acc    = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (ex_redirect) begin
               // The instruction in ID is squashed, so its load-use stall is moot.
               pflush_c     = 1'b1;
               ifid_flush_c = 1'b1;
               redirect_acc = 1'b1;
               if (FLUSH_CYCLES > 0) begin
                  state_d = ST_FLUSH;
                  cnt_d   = FLUSH_LOAD;
               end
            end else if (ex_mc_start) begin
               pc_hold_c      = 1'b1;
               ifid_hold_c    = 1'b1;
               idex_hold_c    = 1'b1;
               exmem_bubble_c = 1'b1;
               tmo_d          = '0;
               state_d        = ST_MC_WAIT;
            end else if (hazard) begin
               pc_hold_c       = 1'b1;
               ifid_hold_c     = 1'b1;
               idex_hazarded_c = 1'b1;
            end
         end

         ST_MC_WAIT: begin
            tmo_d = tmo_q + 1'b1;
            if (mc_done) begin
               state_d = ST_RUN;
            end else if (tmo_q == TMO_LAST) begin
               mc_timeout_c = 1'b1;
               state_d      = ST_RUN;
            end else begin
               pc_hold_c      = 1'b1;
               ifid_hold_c    = 1'b1;
               idex_hold_c    = 1'b1;
               exmem_bubble_c = 1'b1;
            end
         end

         ST_FLUSH: begin
            ifid_flush_c = 1'b1;
            if (ex_redirect) begin
               pflush_c     = 1'b1;
               redirect_acc = 1'b1;
               cnt_d        = FLUSH_LOAD;
            end else begin
               if (cnt_q <= 3'd1) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
               if (hazard) begin
                  pc_hold_c       = 1'b1;
                  ifid_hold_c     = 1'b1;
                  idex_hazarded_c = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs are Mealy, so they must be masked while reset is held.
   assign pc_hold       = rst & pc_hold_c;
   assign ifid_hold     = rst & ifid_hold_c;
   assign ifid_flush    = rst & ifid_flush_c;
   assign idex_hold     = rst & idex_hold_c;
   assign idex_hazarded = rst & idex_hazarded_c;
   assign pipelineFlush = rst & pflush_c;
   assign exmem_bubble  = rst & exmem_bubble_c;
   assign mc_timeout    = rst & mc_timeout_c;
   assign state_o       = rst ? state_q : ST_RUN;

`ifdef PIPE_CTRL_PERF_EN
   logic [31:0] stall_q, stall_d;
   logic [15:0] flushcnt_q, flushcnt_d;

   always_comb begin
      stall_d    = stall_q;
      flushcnt_d = flushcnt_q;
      if (pc_hold && (stall_q != '1)) begin
         stall_d = stall_q + 32'd1;
      end
      if (rst && redirect_acc && (flushcnt_q != '1)) begin
         flushcnt_d = flushcnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_q    <= '0;
         flushcnt_q <= '0;
      end else begin
         stall_q    <= stall_d;
         flushcnt_q <= flushcnt_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flushcnt_q;
`endif

endmodule
